irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- 8-input vectored interrupt controller for the RISC core.
- Latches rising edges on external request lines into a pending register and applies a software mask.
- Selects the highest-priority unmasked source (bit 0 highest) through the existing priority_en encoder.
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU, with one interrupt in service at a time and no nesting.

Parameters:
- ADDR_W, 8: width of the vector address output.
- VEC_BASE, 8'hE0: base of the vector table; each entry is 4 address units.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  8  interrupt request lines, already synchronous to clk; rising-edge sensitive.
- mask_we  in  1  write strobe for the mask register.
- mask_wdata  in  8  new mask value; 1 = source masked.
- mask_q  out  8  current mask register.
- pending_q  out  8  current pending register.
- irq_req  out  1  interrupt request to the CPU (registered).
- irq_id  out  3  source number being requested or serviced.
- irq_vec  out  ADDR_W  vector address of irq_id.
- irq_ack  in  1  CPU accepts the request; single-cycle pulse.
- eoi  in  1  CPU end-of-interrupt; single-cycle pulse.
- in_service  out  1  high while the CPU is servicing an interrupt.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - pending=0, mask=8'hFF (all masked), irq_prev=0.
  - irq_req=0, irq_id=0, irq_vec=VEC_BASE, in_service=0.
  - Reset mid-REQ or mid-SERVICE aborts the handshake immediately; no pending state survives.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - edge = irq_in & ~irq_prev.
  - pending |= edge on each clock.
- Pending and mask:
  - An edge on a bit that is already pending is lost; there is no counting.
  - Masked sources still latch pending.
  - mask_we updates the mask on the next edge.
- Selection: the encoder input is pending & ~mask; its ok output gates selection.
- State machine:
  - IDLE: if encoder ok, latch irq_id <= encoder out, set irq_req <= 1, go to REQ.
  - REQ:
    - irq_id is frozen. A higher-priority arrival does not preempt an outstanding request.
    - If irq_ack: clear pending[irq_id], set irq_req <= 0 and in_service <= 1, go to SERVICE.
    - Else if mask (after this cycle's mask_we) covers irq_id: withdraw (irq_req <= 0, go to IDLE). The pending bit is kept.
    - Ack wins over a same-cycle mask write.
  - SERVICE: on eoi, in_service <= 0, go to IDLE. The next request may assert on the following edge.
- Handshake rules:
  - irq_ack outside REQ is ignored.
  - eoi outside SERVICE is ignored.
- Latency: irq_in rises before edge k; pending is set at edge k; irq_req is high after edge k+1, giving 2 cycles. From eoi at edge j, a queued unmasked request re-asserts irq_req after edge j+1.
- Simultaneous events: a new edge on the same bit in the ack cycle re-sets pending, because set beats clear.
- Vector computation:
  - irq_vec = VEC_BASE + {irq_id, 2'b00}, computed in ADDR_W bits and wrapping modulo 2^ADDR_W.
  - Registered alongside irq_id; stable through REQ and SERVICE.

Decomposition:
- Shared package irq_pkg holds:
  - state encoding IDLE/REQ/SERVICE (2 bits).
  - NUM_IRQ=8, ID_W=3.
  - reset mask 8'hFF.
  - vector stride 4.
- One sub-module: instantiate the existing priority_en (8-bit data in, 3-bit out, ok) for selection.
- Do not duplicate the encoder logic.

Test Plan:
- Reset: assert rst_n=0 mid-SERVICE -> all outputs are reset values immediately, asynchronously.
- Reset: mask_q=8'hFF and pending_q=0 after release.
- Single source: mask=8'h00, irq_in[3] rises before edge 10.
  - pending_q=8'h08 after edge 10.
  - irq_req=1, irq_id=3, irq_vec=8'hEC after edge 11.
  - irq_ack at edge 13 -> pending_q=0, in_service=1, irq_req=0.
  - eoi -> in_service=0.
- Priority: irq_in[1] and irq_in[5] rise together -> id 1 (vec 8'hE4) served first; after its eoi, id 5 (vec 8'hF4) requested one edge later.
- Masking: mask=8'h04, irq_in[2] rises.
  - pending_q=8'h04 and irq_req stays 0.
  - Write mask=8'h00 -> irq_req=1, irq_id=2 two edges after mask_we.
- Withdraw: during REQ for id 0, write mask=8'h01 -> irq_req=0 after the next edge, state IDLE, pending_q[0] still 1.
- Same-cycle: irq_in[4] re-rises on the edge where irq_ack is sampled for id 4 -> pending_q[4]=1 and in_service=1.
- Wrap: VEC_BASE=8'hF8, id 7 -> irq_vec=8'h14.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and constants for the vectored interrupt controller.
// Latency: none (definitions only); backpressure: n/a.
package irq_pkg;

    localparam int NUM_IRQ    = 8;
    localparam int ID_W       = 3;
    localparam int VEC_STRIDE = 4;

    localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/priority_en.sv
// 8-to-3 priority encoder, bit 0 highest priority; ok flags any bit set.
// Latency: combinational; backpressure: n/a.
module priority_en (
    input  logic [7:0] din,
    output logic [2:0] dout,
    output logic       ok
);

    always_comb begin
        dout = 3'd0;
        ok   = |din;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = 7; i >= 0; i--) begin
            if (din[i]) begin
                dout = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// 8-source vectored interrupt controller: edge-latched pending, mask, req/ack/eoi.
// Latency: input edge to irq_req is 2 cycles; one interrupt in service, no nesting.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] VEC_BASE = 8'hE0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         irq_in,
    input  logic               mask_we,
    input  logic [7:0]         mask_wdata,
    output logic [7:0]         mask_q,
    output logic [7:0]         pending_q,
    output logic               irq_req,
    output logic [2:0]         irq_id,
    output logic [ADDR_W-1:0]  irq_vec,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               in_service
);

    state_e              state_q, state_d;
    logic [7:0]          irq_prev_q;
    logic [7:0]          mask_d, pending_d;
    logic                irq_req_q, irq_req_d;
    logic [ID_W-1:0]     irq_id_q, irq_id_d;
    logic [ADDR_W-1:0]   irq_vec_q, irq_vec_d;
    logic                in_service_q, in_service_d;

    logic [7:0]          rise;
    logic [7:0]          enc_in;
    logic [ID_W-1:0]     enc_id;
    logic                enc_ok;

    assign rise   = irq_in & ~irq_prev_q;
    assign enc_in = pending_q & ~mask_q;

    priority_en u_enc (
        .din  (enc_in),
        .dout (enc_id),
        .ok   (enc_ok)
    );

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_we ? mask_wdata : mask_q;
        pending_d    = pending_q;
        irq_req_d    = irq_req_q;
        irq_id_d     = irq_id_q;
        irq_vec_d    = irq_vec_q;
        in_service_d = in_service_q;

        case (state_q)
            IDLE: begin
                if (enc_ok) begin
                    irq_id_d  = enc_id;
                    irq_vec_d = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(enc_id);
                    irq_req_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                // Ack takes precedence over a mask write landing in the same cycle.
                if (irq_ack) begin
                    pending_d[irq_id_q] = 1'b0;
                    irq_req_d           = 1'b0;
                    in_service_d        = 1'b1;
                    state_d             = SERVICE;
                end else if (mask_d[irq_id_q]) begin
                    irq_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A fresh edge re-sets pending even on the bit being acknowledged.
        pending_d = pending_d | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            irq_prev_q   <= 8'h00;
            mask_q       <= MASK_RST;
            pending_q    <= 8'h00;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            irq_vec_q    <= VEC_BASE;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_prev_q   <= irq_in;
            mask_q       <= mask_d;
            pending_q    <= pending_d;
            irq_req_q    <= irq_req_d;
            irq_id_q     <= irq_id_d;
            irq_vec_q    <= irq_vec_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_req    = irq_req_q;
    assign irq_id     = irq_id_q;
    assign irq_vec    = irq_vec_q;
    assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: behavioural model compared every cycle plus directed literal checks.
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_in = 8'h00;
    logic       mask_we = 1'b0;
    logic [7:0] mask_wdata = 8'h00;
    logic       irq_ack = 1'b0;
    logic       eoi = 1'b0;

    logic [7:0] mask_q, pending_q;
    logic       irq_req, in_service;
    logic [2:0] irq_id;
    logic [7:0] irq_vec;

    logic [7:0] mask_q2, pending_q2;
    logic       irq_req2, in_service2;
    logic [2:0] irq_id2;
    logic [7:0] irq_vec2;

    always #5 clk = ~clk;

    irq_ctrl #(.ADDR_W(8), .VEC_BASE(8'hE0)) dut (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .mask_q(mask_q), .pending_q(pending_q),
        .irq_req(irq_req), .irq_id(irq_id), .irq_vec(irq_vec),
        .irq_ack(irq_ack), .eoi(eoi), .in_service(in_service)
    );

    irq_ctrl #(.ADDR_W(8), .VEC_BASE(8'hF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .irq_in(irq_in),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .mask_q(mask_q2), .pending_q(pending_q2),
        .irq_req(irq_req2), .irq_id(irq_id2), .irq_vec(irq_vec2),
        .irq_ack(irq_ack), .eoi(eoi), .in_service(in_service2)
    );

    int checks = 0;
    int errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 = nothing outstanding, 1 = awaiting ack, 2 = being serviced.
    logic [7:0] m_pend  = 8'h00;
    logic [7:0] m_mask  = 8'hFF;
    logic [7:0] m_prev  = 8'h00;
    int         m_phase = 0;
    int         m_id    = 0;
    logic [7:0] m_rises, m_newmask, m_avail;

    function automatic int lowest_set(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend  = 8'h00;
            m_mask  = 8'hFF;
            m_prev  = 8'h00;
            m_phase = 0;
            m_id    = 0;
        end else begin
            m_rises   = irq_in & ~m_prev;
            m_newmask = mask_we ? mask_wdata : m_mask;
            m_avail   = m_pend & ~m_mask;
            if (m_phase == 0) begin
                if (m_avail != 8'h00) begin
                    m_id    = lowest_set(m_avail);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (irq_ack) begin
                    m_pend[m_id] = 1'b0;
                    m_phase      = 2;
                end else if (m_newmask[m_id]) begin
                    m_phase = 0;
                end
            end else if (eoi) begin
                m_phase = 0;
            end
            m_pend = m_pend | m_rises;
            m_mask = m_newmask;
            m_prev = irq_in;
        end
    end

    always @(negedge clk) begin
        check("model_mask",    mask_q,     m_mask);
        check("model_pending", pending_q,  m_pend);
        check("model_req",     irq_req,    (m_phase == 1) ? 1 : 0);
        check("model_insvc",   in_service, (m_phase == 2) ? 1 : 0);
        check("model_id",      irq_id,     m_id);
        check("model_vec",     irq_vec,    (224 + 4 * m_id) % 256);
        check("model_vec_wrap", irq_vec2,  (248 + 4 * m_id) % 256);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ack_then_eoi();
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        eoi = 1'b1; cyc(1); eoi = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("rst_mask", mask_q, 8'hFF);
        check("rst_pending", pending_q, 8'h00);
        check("rst_req", irq_req, 0);
        check("rst_vec", irq_vec, 8'hE0);

        // Single source on line 3
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(1); mask_we = 1'b0;
        irq_in = 8'h08; cyc(1);
        check("single_pend", pending_q, 8'h08);
        check("single_req_early", irq_req, 0);
        cyc(1);
        check("single_req", irq_req, 1);
        check("single_id", irq_id, 3);
        check("single_vec", irq_vec, 8'hEC);
        cyc(1);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        check("single_ack_pend", pending_q, 8'h00);
        check("single_ack_insvc", in_service, 1);
        check("single_ack_req", irq_req, 0);
        cyc(1);
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        check("single_eoi", in_service, 0);
        irq_in = 8'h00; cyc(1);

        // Priority between lines 1 and 5
        irq_in = 8'h22; cyc(1);
        check("prio_pend", pending_q, 8'h22);
        cyc(1);
        check("prio_req1", irq_req, 1);
        check("prio_id1", irq_id, 1);
        check("prio_vec1", irq_vec, 8'hE4);
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        check("prio_pend_after_ack", pending_q, 8'h20);
        cyc(1);
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        check("prio_gap_req", irq_req, 0);
        cyc(1);
        check("prio_req5", irq_req, 1);
        check("prio_id5", irq_id, 5);
        check("prio_vec5", irq_vec, 8'hF4);
        ack_then_eoi();
        irq_in = 8'h00; cyc(1);

        // Masked source still latches pending
        mask_we = 1'b1; mask_wdata = 8'h04; cyc(1); mask_we = 1'b0;
        irq_in = 8'h04; cyc(3);
        check("mask_pend", pending_q, 8'h04);
        check("mask_noreq", irq_req, 0);
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(1); mask_we = 1'b0;
        check("unmask_req_early", irq_req, 0);
        cyc(1);
        check("unmask_req", irq_req, 1);
        check("unmask_id", irq_id, 2);
        ack_then_eoi();

        // Withdraw on mask during REQ
        irq_in = 8'h01; cyc(2);
        check("wd_req", irq_req, 1);
        check("wd_id", irq_id, 0);
        mask_we = 1'b1; mask_wdata = 8'h01; cyc(1); mask_we = 1'b0;
        check("wd_req_drop", irq_req, 0);
        check("wd_pend0", pending_q[0], 1);
        check("wd_insvc", in_service, 0);
        cyc(1);
        check("wd_stays_idle", irq_req, 0);
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(1); mask_we = 1'b0;
        cyc(1);
        check("wd_rereq", irq_req, 1);
        ack_then_eoi();

        // Same-cycle re-edge during ack
        irq_in = 8'h11; cyc(2);
        check("sc_req", irq_req, 1);
        check("sc_id", irq_id, 4);
        irq_in = 8'h01; cyc(1);
        irq_in = 8'h11; irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        check("sc_pend4", pending_q, 8'h10);
        check("sc_insvc", in_service, 1);
        cyc(1);
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        cyc(1);
        check("sc_rereq", irq_req, 1);
        check("sc_reid", irq_id, 4);

        // Asynchronous reset mid-SERVICE
        irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
        check("ar_insvc_before", in_service, 1);
        irq_in = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("ar_req", irq_req, 0);
        check("ar_insvc", in_service, 0);
        check("ar_pend", pending_q, 8'h00);
        check("ar_mask", mask_q, 8'hFF);
        check("ar_id", irq_id, 0);
        check("ar_vec", irq_vec, 8'hE0);
        check("ar_vec_wrap", irq_vec2, 8'hF8);
        cyc(1);
        rst_n = 1'b1;

        // Vector wrap on id 7
        mask_we = 1'b1; mask_wdata = 8'h00; cyc(1); mask_we = 1'b0;
        irq_in = 8'h80; cyc(2);
        check("wrap_req", irq_req2, 1);
        check("wrap_id", irq_id2, 7);
        check("wrap_vec", irq_vec2, 8'h14);
        check("wrap_vec_e0", irq_vec, 8'hFC);
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
